// File: rtl/md_pos_pkg.sv
// Shared definitions for the position-cache reader: default widths, FSM encoding and
// the location of the particle-count field in the address-0 cache word.
package md_pos_pkg;

  localparam int unsigned DefOffsetWidth     = 29;
  localparam int unsigned DefParticleIdWidth = 7;
  localparam int unsigned DefPosCacheDepth   = 128;

  // The particle count sits in the low PARTICLE_ID_WIDTH bits of cache word 0.
  localparam int unsigned CountLsb = 0;

  typedef enum logic [2:0] {
    StIdle,
    StRdNum,
    StWaitNum,
    StStream,
    StDrain,
    StDone
  } rd_state_e;

endpackage

// File: rtl/pos_reader_fifo2.sv
// Two-entry FIFO with simultaneous push/pop; holds the particle records that have
// returned from the cache and are waiting for the downstream consumer.
module pos_reader_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [Width-1:0] mem_q [2];
  logic             wptr_q, rptr_q;
  logic [1:0]       cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == 2'd2);
  assign empty   = (cnt_q == 2'd0);
  assign count   = cnt_q;
  assign rdata   = mem_q[rptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) begin
        rptr_q <= ~rptr_q;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // The reader's issue throttle must make this unreachable.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst) push |-> !full)
    else $error("pos_reader_fifo2: push into full FIFO");

endmodule

// File: rtl/pos_cache_reader.sv
// Sweeps one cell of the position cache: reads the particle count from address 0, then
// streams addresses 1..N through a 2-entry buffer under valid/ready flow control.
module pos_cache_reader
  import md_pos_pkg::*;
#(
  parameter int unsigned OFFSET_WIDTH      = DefOffsetWidth,
  parameter int unsigned PARTICLE_ID_WIDTH = DefParticleIdWidth,
  parameter int unsigned POS_CACHE_DEPTH   = DefPosCacheDepth
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic [PARTICLE_ID_WIDTH-1:0] cache_rd_addr,
  output logic                         cache_rden,
  input  logic [3*OFFSET_WIDTH-1:0]    cache_rd_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PARTICLE_ID_WIDTH-1:0] out_particle_id,
  output logic [3*OFFSET_WIDTH-1:0]    out_particle_data,
  output logic [PARTICLE_ID_WIDTH-1:0] particle_count,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned DataW = 3 * OFFSET_WIDTH;
  localparam int unsigned RecW  = PARTICLE_ID_WIDTH + DataW;

  rd_state_e state_q, state_d;

  logic [PARTICLE_ID_WIDTH-1:0] addr_q, addr_d;
  logic [PARTICLE_ID_WIDTH-1:0] count_q, count_d;
  logic [PARTICLE_ID_WIDTH-1:0] flight_addr_q;
  logic                         inflight_q;
  logic                         issue;
  logic                         pop;
  logic [1:0]                   occ, occ_after, load;
  logic                         fifo_full, fifo_empty;
  logic [RecW-1:0]              fifo_rdata;

  assign out_valid         = !fifo_empty;
  assign pop               = out_valid && out_ready;
  assign out_particle_id   = fifo_rdata[RecW-1 -: PARTICLE_ID_WIDTH];
  assign out_particle_data = fifo_rdata[DataW-1:0];
  assign particle_count    = count_q;
  assign busy              = (state_q != StIdle);
  assign done              = (state_q == StDone);

  // Occupancy is taken after this cycle's pop so a full-rate consumer keeps reads flowing.
  assign occ_after = occ - {1'b0, pop};
  assign load      = occ_after + {1'b0, inflight_q};

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    count_d       = count_q;
    issue         = 1'b0;
    cache_rden    = 1'b0;
    cache_rd_addr = '0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRdNum;
      end
      StRdNum: begin
        cache_rden = 1'b1;
        state_d    = StWaitNum;
      end
      StWaitNum: begin
        count_d = cache_rd_data[CountLsb +: PARTICLE_ID_WIDTH];
        addr_d  = PARTICLE_ID_WIDTH'(1);
        state_d = (count_d == '0) ? StDone : StStream;
      end
      StStream: begin
        if (load < 2'd2) begin
          issue         = 1'b1;
          cache_rden    = 1'b1;
          cache_rd_addr = addr_q;
          addr_d        = addr_q + PARTICLE_ID_WIDTH'(1);
          if (addr_q == count_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty && !inflight_q) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      count_q       <= '0;
      flight_addr_q <= '0;
      inflight_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      inflight_q <= issue;
      if (issue) flight_addr_q <= cache_rd_addr;
    end
  end

  pos_reader_fifo2 #(
    .Width (RecW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .wdata ({flight_addr_q, cache_rd_data}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occ)
  );

  a_count_fits : assert property (@(posedge clk) disable iff (!rst)
      (state_q == StWaitNum) |->
      (32'(cache_rd_data[CountLsb +: PARTICLE_ID_WIDTH]) < POS_CACHE_DEPTH))
    else $error("pos_cache_reader: particle count exceeds cache depth");

endmodule

// File: tb/tb_pos_cache_reader.sv
// Directed sweeps with randomized cache contents and consumer backpressure, checked
// against an expected-record queue built from the cache image.
module tb_pos_cache_reader;

  localparam int OW    = 29;
  localparam int PW    = 7;
  localparam int DW    = 3 * OW;
  localparam int Depth = 128;

  logic          clk, rst, start, out_ready;
  logic [PW-1:0] cache_rd_addr, out_particle_id, particle_count;
  logic          cache_rden, out_valid, busy, done;
  logic [DW-1:0] cache_rd_data, out_particle_data;

  logic [DW-1:0] mem [Depth];

  logic [PW-1:0] exp_id [$];
  logic [DW-1:0] exp_data [$];

  int n_assert = 0;
  int n_fail   = 0;

  int sweep_n, issued, accepted, rd0, dones, cyc;
  int first_valid, first_acc, last_acc, done_cyc;
  int next_addr;
  bit stall_q;
  logic [PW-1:0] held_id;
  logic [DW-1:0] held_data;

  pos_cache_reader #(
    .OFFSET_WIDTH      (OW),
    .PARTICLE_ID_WIDTH (PW),
    .POS_CACHE_DEPTH   (Depth)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cache_rd_addr     (cache_rd_addr),
    .cache_rden        (cache_rden),
    .cache_rd_data     (cache_rd_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_particle_id   (out_particle_id),
    .out_particle_data (out_particle_data),
    .particle_count    (particle_count),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read cache: data valid the cycle after the read enable.
  always @(posedge clk) begin
    if (cache_rden) cache_rd_data <= mem[cache_rd_addr];
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then observe what the
  // next rising edge will commit.
  task automatic tick(input logic rdy, input logic st);
    logic [PW-1:0] eid;
    logic [DW-1:0] edat;
    @(negedge clk);
    out_ready = rdy;
    start     = st;
    #1;
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (out_valid && stall_q) begin
      chk("stall_id", out_particle_id, held_id);
      chk("stall_data", out_particle_data, held_data);
    end
    if (out_valid && out_ready) begin
      if (accepted >= sweep_n) begin
        chk("extra_record", accepted + 1, sweep_n);
      end else begin
        eid  = exp_id.pop_front();
        edat = exp_data.pop_front();
        chk("rec_id", out_particle_id, eid);
        chk("rec_data", out_particle_data, edat);
      end
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      accepted++;
    end
    stall_q   = out_valid && !out_ready;
    held_id   = out_particle_id;
    held_data = out_particle_data;
    if (cache_rden) begin
      if (cache_rd_addr == '0) begin
        rd0++;
      end else begin
        chk("rd_addr", cache_rd_addr, next_addr);
        next_addr++;
        issued++;
        chk("load_le2", (issued - accepted) <= 2, 1);
      end
    end
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  function automatic logic ready_for(input int mode, input int c);
    case (mode)
      0:       return 1'b1;
      1:       return (c % 3) == 1;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic check_reset_outputs();
    chk("rst_valid", out_valid, 0);
    chk("rst_rden", cache_rden, 0);
    chk("rst_addr", cache_rd_addr, 0);
    chk("rst_id", out_particle_id, 0);
    chk("rst_data", out_particle_data, 0);
    chk("rst_count", particle_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  // restart_at: cycle at which a spurious start is pulsed (0 = none);
  // abort_after: apply reset once this many records are accepted (0 = never).
  task automatic sweep(input int n, input int mode, input int restart_at, input int abort_after);
    int budget;
    exp_id.delete();
    exp_data.delete();
    mem[0] = {$urandom, $urandom, $urandom};
    mem[0][PW-1:0] = n[PW-1:0];
    for (int i = 1; i <= n; i++) begin
      mem[i] = {$urandom, $urandom, $urandom};
      exp_id.push_back(i[PW-1:0]);
      exp_data.push_back(mem[i]);
    end
    sweep_n = n; issued = 0; accepted = 0; rd0 = 0; dones = 0; cyc = 0;
    first_valid = -1; first_acc = -1; last_acc = -1; done_cyc = -1;
    next_addr = 1; stall_q = 0;
    budget = 4 * n + 20;
    tick(ready_for(mode, 0), 1'b1);
    for (int k = 1; k < budget && dones == 0; k++) begin
      tick(ready_for(mode, k), (k == restart_at));
      if (abort_after > 0 && accepted == abort_after) begin
        rst = 1'b0;
        #1;
        check_reset_outputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        return;
      end
    end
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0);
    chk("done_pulses", dones, 1);
    chk("records_left", exp_id.size(), 0);
    chk("accepted", accepted, n);
    chk("reads_issued", issued, n);
    chk("addr0_reads", rd0, 1);
    chk("particle_count", particle_count, n);
    chk("idle_busy", busy, 0);
    if (n > 0) begin
      chk("first_valid_ge4", first_valid >= 4, 1);
      if (mode == 0) chk("back_to_back", last_acc - first_acc, n - 1);
    end else begin
      chk("empty_done_le4", (done_cyc >= 0) && (done_cyc <= 4), 1);
      chk("empty_no_valid", first_valid, -1);
    end
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b0;
    sweep_n   = 0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tick(1'b0, 1'b0);
    chk("idle_busy0", busy, 0);

    sweep(3, 0, 0, 0);
    tick(1'b1, 1'b0);
    sweep(0, 0, 0, 0);
    tick(1'b1, 1'b0);
    sweep(5, 1, 0, 0);
    tick(1'b1, 1'b0);
    sweep(127, 0, 0, 0);
    tick(1'b1, 1'b0);
    sweep(10, 0, 0, 4);
    tick(1'b1, 1'b0);
    sweep(10, 0, 0, 0);
    tick(1'b1, 1'b0);
    sweep(6, 0, 5, 0);
    for (int r = 0; r < 4; r++) begin
      tick(1'b1, 1'b0);
      sweep(int'($urandom_range(1, 30)), 2, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
